// File: rtl/traffic_pkg.sv
// Shared types and constants for the traffic-light controller blocks.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package traffic_pkg;

    // Down-counter control states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2
    } state_t;

    // Default counter geometry.
    localparam int DEF_WIDTH     = 6;
    localparam int DEF_NUM_MODES = 4;

    // Phase indices into the packed durations bus.
    localparam int PH_GREEN  = 0;
    localparam int PH_YELLOW = 1;
    localparam int PH_RED    = 2;
    localparam int PH_ALLRED = 3;

endpackage

// File: rtl/phase_backcounter.sv
// Per-phase seconds down-counter with hold, optional auto-reload and one-cycle timeout strobe.
// Latency: load/pulse effects are visible one cycle after the sampling edge; all outputs registered.
// Backpressure: none; hold freezes the count and drops pulses, load always wins.
module phase_backcounter
    import traffic_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int NUM_MODES   = DEF_NUM_MODES,
    parameter int MODE_W      = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1,
    parameter int AUTO_RELOAD = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       load,
    input  logic [MODE_W-1:0]          mode,
    input  logic [NUM_MODES*WIDTH-1:0] durations,
    input  logic                       pulse,
    input  logic                       hold,
    output logic                       timeout,
    output logic [WIDTH-1:0]           sec_count,
    output logic [MODE_W-1:0]          phase,
    output logic                       busy
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  cnt_q, cnt_d;
    logic [MODE_W-1:0] phase_q, phase_d;
    logic              tout_q, tout_d;
    logic [WIDTH-1:0]  load_dur;
    logic [WIDTH-1:0]  reload_dur;

    // Out-of-range phase indices select a zero duration so they expire at once.
    function automatic logic [WIDTH-1:0] dur_sel(input logic [NUM_MODES*WIDTH-1:0] durs,
                                                 input logic [MODE_W-1:0] idx);
        logic [WIDTH-1:0] d;
        d = '0;
        if (int'(idx) < NUM_MODES) begin
            d = durs[int'(idx)*WIDTH +: WIDTH];
        end
        return d;
    endfunction

    // Duration for a fresh load comes from mode; reload reads the latched phase live.
    always_comb begin
        load_dur   = dur_sel(durations, mode);
        reload_dur = dur_sel(durations, phase_q);
    end

    // Next-state and next-count logic; load beats hold beats pulse.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        phase_d = phase_q;
        tout_d  = 1'b0;
        if (load) begin
            phase_d = mode;
            cnt_d   = load_dur;
            if (load_dur == '0) begin
                state_d = IDLE;
                tout_d  = 1'b1;
            end else begin
                state_d = RUN;
            end
        end else begin
            unique case (state_q)
                RUN: begin
                    if (hold) begin
                        state_d = PAUSED;
                    end else if (pulse) begin
                        if (cnt_q > ONE) begin
                            cnt_d = cnt_q - ONE;
                        end else begin
                            tout_d = 1'b1;
                            if ((AUTO_RELOAD != 0) && (reload_dur != '0)) begin
                                cnt_d = reload_dur;
                            end else begin
                                cnt_d   = '0;
                                state_d = IDLE;
                            end
                        end
                    end
                end
                PAUSED: begin
                    if (!hold) begin
                        state_d = RUN;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // State and output registers; reset drops any pending timeout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            phase_q <= '0;
            tout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            tout_q  <= tout_d;
        end
    end

    assign timeout   = tout_q;
    assign sec_count = cnt_q;
    assign phase     = phase_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_phase_backcounter.sv
// Bench for phase_backcounter: two instances (AUTO_RELOAD 0 and 1) share stimulus.
// Latency: outputs compared 1 time unit after each rising edge against a phase-timer model.
// Backpressure: n/a.
module tb_phase_backcounter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [23:0] durations = 24'd0;
    logic        pulse = 1'b0;
    logic        hold = 1'b0;

    logic       timeout0, busy0, timeout1, busy1;
    logic [5:0] sec0, sec1;
    logic [1:0] phase0, phase1;
    logic [9:0] obs [2];

    int checks = 0;
    int errors = 0;

    // Model: a phase timer is either stopped, running, or paused, with seconds left.
    bit         m_run   [2];
    bit         m_pause [2];
    bit         m_tout  [2];
    logic [5:0] m_cnt   [2];
    logic [1:0] m_phase [2];

    phase_backcounter #(.WIDTH(6), .NUM_MODES(4), .AUTO_RELOAD(0)) u_ar0 (
        .clk(clk), .rst(rst), .load(load), .mode(mode), .durations(durations),
        .pulse(pulse), .hold(hold), .timeout(timeout0), .sec_count(sec0),
        .phase(phase0), .busy(busy0)
    );

    phase_backcounter #(.WIDTH(6), .NUM_MODES(4), .AUTO_RELOAD(1)) u_ar1 (
        .clk(clk), .rst(rst), .load(load), .mode(mode), .durations(durations),
        .pulse(pulse), .hold(hold), .timeout(timeout1), .sec_count(sec1),
        .phase(phase1), .busy(busy1)
    );

    assign obs[0] = {timeout0, busy0, phase0, sec0};
    assign obs[1] = {timeout1, busy1, phase1, sec1};

    always #5 clk = ~clk;

    function automatic logic [5:0] dur_of(input int m);
        if (m >= 4) return 6'd0;
        return durations[m*6 +: 6];
    endfunction

    function automatic logic [9:0] model_vec(input int k);
        return {m_tout[k], m_run[k], m_phase[k], m_cnt[k]};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_run[k] = 0; m_pause[k] = 0; m_tout[k] = 0;
            m_cnt[k] = 6'd0; m_phase[k] = 2'd0;
        end
    endtask

    // One second of the phase timer, as seen by a controller at each clock edge.
    task automatic model_edge(input int k);
        logic [5:0] d;
        m_tout[k] = 0;
        if (load) begin
            d = dur_of(int'(mode));
            m_phase[k] = mode;
            m_cnt[k] = d;
            m_pause[k] = 0;
            m_run[k] = (d != 0);
            m_tout[k] = (d == 0);
        end else if (m_run[k] && !m_pause[k]) begin
            if (hold) begin
                m_pause[k] = 1;
            end else if (pulse) begin
                if (m_cnt[k] > 1) begin
                    m_cnt[k] = m_cnt[k] - 1;
                end else begin
                    m_tout[k] = 1;
                    d = dur_of(int'(m_phase[k]));
                    if (k == 1 && d != 0) begin
                        m_cnt[k] = d;
                    end else begin
                        m_cnt[k] = 0;
                        m_run[k] = 0;
                    end
                end
            end
        end else if (m_run[k] && m_pause[k] && !hold) begin
            m_pause[k] = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        #1;
    endtask

    // Apply one cycle of stimulus; load and pulse are strobes, hold is a level.
    task automatic cyc(input bit l, input logic [1:0] m, input bit p, input bit h);
        load = l; mode = m; pulse = p; hold = h;
        tick();
        load = 0; pulse = 0;
    endtask

    task automatic test_reset();
        #12;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (obs[k] !== 10'd0) begin
                errors++;
                $display("FAIL reset_state inst%0d: got %h, expected 000", k, obs[k]);
            end
        end
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_countdown();
        durations = {6'd1, 6'd7, 6'd2, 6'd5};
        cyc(1, 2'd0, 0, 0);
        checks++;
        if (sec0 !== 6'd5 || busy0 !== 1'b1) begin
            errors++;
            $display("FAIL countdown_load: sec=%0d busy=%b, expected sec=5 busy=1", sec0, busy0);
        end
        for (int i = 1; i <= 5; i++) begin
            for (int j = 0; j < 3; j++) cyc(0, 2'd0, 0, 0);
            cyc(0, 2'd0, 1, 0);
            checks++;
            if (sec0 !== 6'(5 - i) || timeout0 !== (i == 5)) begin
                errors++;
                $display("FAIL countdown_pulse%0d: sec=%0d tout=%b, expected sec=%0d tout=%b",
                         i, sec0, timeout0, 5 - i, (i == 5));
            end
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs[k] !== model_vec(k)) begin
                    errors++;
                    $display("FAIL countdown_model inst%0d: got %h, expected %h", k, obs[k], model_vec(k));
                end
            end
        end
        checks++;
        if (busy0 !== 1'b0) begin
            errors++;
            $display("FAIL countdown_busy_fall: busy=%b, expected 0", busy0);
        end
        cyc(0, 2'd0, 0, 0);
        checks++;
        if (timeout0 !== 1'b0 || busy0 !== 1'b0) begin
            errors++;
            $display("FAIL countdown_after: tout=%b busy=%b, expected 0 0", timeout0, busy0);
        end
    endtask

    task automatic test_hold();
        int npulse;
        int seen_at;
        durations = {6'd1, 6'd7, 6'd2, 6'd5};
        cyc(1, 2'd2, 0, 0);
        npulse = 0;
        seen_at = 0;
        for (int i = 0; i < 40 && seen_at == 0; i++) begin
            bit h;
            bit p;
            h = (npulse >= 2 && npulse < 4);
            p = (i % 3 == 2);
            if (p) npulse++;
            cyc(0, 2'd0, p, h);
            if (h) begin
                checks++;
                if (sec0 !== 6'd5) begin
                    errors++;
                    $display("FAIL hold_frozen: sec=%0d, expected 5", sec0);
                end
            end
            if (timeout0 === 1'b1) seen_at = npulse;
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs[k] !== model_vec(k)) begin
                    errors++;
                    $display("FAIL hold_model inst%0d: got %h, expected %h", k, obs[k], model_vec(k));
                end
            end
        end
        hold = 0;
        checks++;
        if (seen_at != 9) begin
            errors++;
            $display("FAIL hold_total_pulses: timeout after %0d pulses, expected 9", seen_at);
        end
    endtask

    task automatic test_autoreload();
        int touts;
        durations = {6'd1, 6'd7, 6'd2, 6'd5};
        cyc(1, 2'd1, 0, 0);
        touts = 0;
        for (int i = 1; i <= 6; i++) begin
            cyc(0, 2'd0, 0, 0);
            cyc(0, 2'd0, 1, 0);
            if (timeout1 === 1'b1) touts++;
            checks++;
            if (sec1 !== ((i % 2 == 1) ? 6'd1 : 6'd2) || busy1 !== 1'b1) begin
                errors++;
                $display("FAIL autoreload_pulse%0d: sec=%0d busy=%b", i, sec1, busy1);
            end
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs[k] !== model_vec(k)) begin
                    errors++;
                    $display("FAIL autoreload_model inst%0d: got %h, expected %h", k, obs[k], model_vec(k));
                end
            end
        end
        checks++;
        if (touts != 3) begin
            errors++;
            $display("FAIL autoreload_count: %0d timeouts, expected 3", touts);
        end
    endtask

    task automatic test_zero_duration();
        durations = {6'd0, 6'd7, 6'd2, 6'd5};
        cyc(1, 2'd3, 0, 0);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (obs[k] !== {1'b1, 1'b0, 2'd3, 6'd0}) begin
                errors++;
                $display("FAIL zero_dur inst%0d: got %h, expected %h", k, obs[k], {1'b1, 1'b0, 2'd3, 6'd0});
            end
        end
        cyc(0, 2'd0, 1, 0);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (obs[k] !== model_vec(k)) begin
                errors++;
                $display("FAIL zero_dur_after inst%0d: got %h, expected %h", k, obs[k], model_vec(k));
            end
        end
    endtask

    task automatic test_load_on_expiry();
        durations = {6'd1, 6'd7, 6'd2, 6'd5};
        cyc(1, 2'd3, 0, 0);
        cyc(1, 2'd0, 1, 0);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (obs[k] !== {1'b0, 1'b1, 2'd0, 6'd5}) begin
                errors++;
                $display("FAIL load_beats_expiry inst%0d: got %h, expected %h", k, obs[k], {1'b0, 1'b1, 2'd0, 6'd5});
            end
        end
    endtask

    task automatic test_async_reset();
        durations = {6'd1, 6'd7, 6'd2, 6'd5};
        cyc(1, 2'd2, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 2'd0, 1, 0);
        checks++;
        if (sec0 !== 6'd3) begin
            errors++;
            $display("FAIL reset_pre: sec=%0d, expected 3", sec0);
        end
        #2;
        rst = 1;
        #1;
        model_reset();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (obs[k] !== 10'd0) begin
                errors++;
                $display("FAIL async_reset inst%0d: got %h, expected 000", k, obs[k]);
            end
        end
        @(negedge clk);
        rst = 0;
        for (int i = 0; i < 3; i++) begin
            cyc(0, 2'd0, 1, 0);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs[k] !== 10'd0) begin
                    errors++;
                    $display("FAIL reset_idle_pulse inst%0d: got %h, expected 000", k, obs[k]);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 31) == 0) begin
                for (int m = 0; m < 4; m++) durations[m*6 +: 6] = 6'($urandom_range(0, 6));
            end
            hold = ($urandom_range(0, 7) == 0);
            cyc(($urandom_range(0, 15) == 0), 2'($urandom_range(0, 3)),
                ($urandom_range(0, 2) == 0), hold);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs[k] !== model_vec(k)) begin
                    errors++;
                    $display("FAIL random_cycle%0d inst%0d: got %h, expected %h", i, k, obs[k], model_vec(k));
                end
            end
        end
        hold = 0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_countdown();
        test_hold();
        test_autoreload();
        test_zero_duration();
        test_load_on_expiry();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
